// File: rtl/csr_pkg.sv
// ============================================================================
// Module   : csr_pkg
// Desc     : Shared constants for the machine-mode trap CSR file: addresses,
//            mstatus/mie/mip bit positions, mtvec modes and cause codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] c_addr_mstatus   = 12'h300;
    localparam logic [11:0] c_addr_misa      = 12'h301;
    localparam logic [11:0] c_addr_mie       = 12'h304;
    localparam logic [11:0] c_addr_mtvec     = 12'h305;
    localparam logic [11:0] c_addr_mscratch  = 12'h340;
    localparam logic [11:0] c_addr_mepc      = 12'h341;
    localparam logic [11:0] c_addr_mcause    = 12'h342;
    localparam logic [11:0] c_addr_mtval     = 12'h343;
    localparam logic [11:0] c_addr_mip       = 12'h344;
    localparam logic [11:0] c_addr_mcycle    = 12'hB00;
    localparam logic [11:0] c_addr_minstret  = 12'hB02;
    localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
    localparam logic [11:0] c_addr_minstreth = 12'hB82;
    localparam logic [11:0] c_addr_mvendorid = 12'hF11;
    localparam logic [11:0] c_addr_marchid   = 12'hF12;
    localparam logic [11:0] c_addr_mimpid    = 12'hF13;
    localparam logic [11:0] c_addr_mhartid   = 12'hF14;

    localparam int c_mstatus_mie  = 3;
    localparam int c_mstatus_mpie = 7;

    // mie/mip bit positions coincide with the interrupt cause codes
    localparam int c_irq_msi = 3;
    localparam int c_irq_mti = 7;
    localparam int c_irq_mei = 11;

    localparam logic [31:0] c_mie_mask  = 32'h0000_0888;
    localparam logic [31:0] c_cause_msi = 32'h8000_0003;
    localparam logic [31:0] c_cause_mti = 32'h8000_0007;
    localparam logic [31:0] c_cause_mei = 32'h8000_000B;

    localparam logic [1:0] c_mtvec_direct   = 2'b00;
    localparam logic [1:0] c_mtvec_vectored = 2'b01;

    localparam logic [31:0] c_misa = 32'h4000_0100;

    // MPP is hard-wired to machine mode
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v = 32'h0000_1800;
        v[c_mstatus_mie]  = mie;
        v[c_mstatus_mpie] = mpie;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_irq_sync.sv
// ============================================================================
// Module   : csr_irq_sync
// Desc     : Reset-cleared flop chain bringing one asynchronous interrupt line
//            into the clk domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_irq,
    output logic o_irq
);

    generate
        if (STAGES <= 1) begin : g_single
            logic r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= 1'b0;
                else        r_sync <= i_irq;
            end
            assign o_irq = r_sync;
        end else begin : g_chain
            logic [STAGES-1:0] r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= '0;
                else        r_sync <= {r_sync[STAGES-2:0], i_irq};
            end
            assign o_irq = r_sync[STAGES-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/csr_file_mtrap.sv
// ============================================================================
// Module   : csr_file_mtrap
// Desc     : Machine-mode CSR file owning trap entry/MRET state, interrupt
//            qualification and trap target PC. Define CSR_COUNTERS_EN to add
//            the 64-bit mcycle/minstret counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_file_mtrap
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID           = 32'd0,
    parameter logic [31:0] RESET_PC          = 32'h0001_0000,
    parameter bit          MTVEC_VECTORED_OK = 1'b1,
    parameter int          IRQ_SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_out,
    output logic        csr_illegal,
    input  logic [11:0] csr_wr_addr,
    input  logic [31:0] csr_data_in,
    input  logic        wr_csr_n,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        is_mret,
    input  logic        instr_retired,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_out
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mscratch;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [29:0] r_mtvec_base;
    logic [1:0]  r_mtvec_mode;

    logic        w_sync_ext;
    logic        w_sync_timer;
    logic        w_sync_sw;
    logic [31:0] w_mip;
    logic [31:0] w_irq_active;
    logic [31:0] w_mtvec;
    logic [1:0]  w_mtvec_mode_nxt;
    logic        w_wr_en;

    csr_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_ext (
        .clk   (clk),
        .rst_n (rst_n),
        .i_irq (ext_irq),
        .o_irq (w_sync_ext)
    );

    csr_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_irq (timer_irq),
        .o_irq (w_sync_timer)
    );

    csr_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .i_irq (sw_irq),
        .o_irq (w_sync_sw)
    );

    always_comb begin
        w_mip            = '0;
        w_mip[c_irq_mei] = w_sync_ext;
        w_mip[c_irq_mti] = w_sync_timer;
        w_mip[c_irq_msi] = w_sync_sw;
    end

    // A trap or MRET in the same cycle swallows any CSR write
    assign w_wr_en = !wr_csr_n && !trap_req && !is_mret;

    always_comb begin
        w_mtvec_mode_nxt = r_mtvec_mode;
        case (csr_data_in[1:0])
            c_mtvec_direct:   w_mtvec_mode_nxt = c_mtvec_direct;
            c_mtvec_vectored: w_mtvec_mode_nxt = MTVEC_VECTORED_OK ? c_mtvec_vectored
                                                                   : c_mtvec_direct;
            default:          w_mtvec_mode_nxt = r_mtvec_mode;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mscratch     <= '0;
            r_mepc         <= RESET_PC[31:2];
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_mtvec_base   <= RESET_PC[31:2];
            r_mtvec_mode   <= c_mtvec_direct;
        end else if (trap_req) begin
            r_mepc         <= trap_pc[31:2];
            r_mcause       <= trap_cause;
            r_mtval        <= trap_val;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (is_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr_en) begin
            case (csr_wr_addr)
                c_addr_mstatus: begin
                    r_mstatus_mie  <= csr_data_in[c_mstatus_mie];
                    r_mstatus_mpie <= csr_data_in[c_mstatus_mpie];
                end
                c_addr_mie:      r_mie      <= csr_data_in & c_mie_mask;
                c_addr_mtvec: begin
                    r_mtvec_base <= csr_data_in[31:2];
                    r_mtvec_mode <= w_mtvec_mode_nxt;
                end
                c_addr_mscratch: r_mscratch <= csr_data_in;
                c_addr_mepc:     r_mepc     <= csr_data_in[31:2];
                c_addr_mcause:   r_mcause   <= csr_data_in;
                c_addr_mtval:    r_mtval    <= csr_data_in;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    // Writing one half freezes the other half for that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    r_mcycle         <= '0;
        else if (w_wr_en && csr_wr_addr == c_addr_mcycle)  r_mcycle[31:0]  <= csr_data_in;
        else if (w_wr_en && csr_wr_addr == c_addr_mcycleh) r_mcycle[63:32] <= csr_data_in;
        else                                           r_mcycle         <= r_mcycle + 64'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          r_minstret         <= '0;
        else if (w_wr_en && csr_wr_addr == c_addr_minstret)  r_minstret[31:0]  <= csr_data_in;
        else if (w_wr_en && csr_wr_addr == c_addr_minstreth) r_minstret[63:32] <= csr_data_in;
        else if (instr_retired)                              r_minstret         <= r_minstret + 64'd1;
    end

    logic [1:0] w_unused_bits;
    assign w_unused_bits = trap_pc[1:0];
`else
    logic [2:0] w_unused_bits;
    assign w_unused_bits = {instr_retired, trap_pc[1:0]};
`endif

    assign w_mtvec = {r_mtvec_base, r_mtvec_mode};

    always_comb begin
        csr_out     = '0;
        csr_illegal = 1'b0;
        case (csr_addr)
            c_addr_mstatus:   csr_out = mstatus_pack(r_mstatus_mie, r_mstatus_mpie);
            c_addr_misa:      csr_out = c_misa;
            c_addr_mie:       csr_out = r_mie;
            c_addr_mtvec:     csr_out = w_mtvec;
            c_addr_mscratch:  csr_out = r_mscratch;
            c_addr_mepc:      csr_out = {r_mepc, 2'b00};
            c_addr_mcause:    csr_out = r_mcause;
            c_addr_mtval:     csr_out = r_mtval;
            c_addr_mip:       csr_out = w_mip;
            c_addr_mvendorid: csr_out = '0;
            c_addr_marchid:   csr_out = '0;
            c_addr_mimpid:    csr_out = '0;
            c_addr_mhartid:   csr_out = HART_ID;
`ifdef CSR_COUNTERS_EN
            c_addr_mcycle:    csr_out = r_mcycle[31:0];
            c_addr_mcycleh:   csr_out = r_mcycle[63:32];
            c_addr_minstret:  csr_out = r_minstret[31:0];
            c_addr_minstreth: csr_out = r_minstret[63:32];
`endif
            default:          csr_illegal = 1'b1;
        endcase
    end

    assign w_irq_active = r_mie & w_mip;
    assign irq_pending  = r_mstatus_mie && (|w_irq_active);

    // Fixed priority MEI > MSI > MTI; MEI is also the idle value
    always_comb begin
        irq_cause = c_cause_mei;
        if (w_irq_active[c_irq_mei])      irq_cause = c_cause_mei;
        else if (w_irq_active[c_irq_msi]) irq_cause = c_cause_msi;
        else if (w_irq_active[c_irq_mti]) irq_cause = c_cause_mti;
    end

    always_comb begin
        trap_target = {r_mtvec_base, 2'b00};
        if (r_mtvec_mode == c_mtvec_vectored && trap_cause[31])
            trap_target = {r_mtvec_base, 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
    end

    assign mepc_out = {r_mepc, 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_csr_file_mtrap.sv
// ============================================================================
// Module   : tb_csr_file_mtrap
// Desc     : Directed self-checking bench for csr_file_mtrap (both mtvec modes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_file_mtrap;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_data_in;
    logic        wr_csr_n;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        is_mret;
    logic        instr_retired;
    logic        ext_irq;
    logic        timer_irq;
    logic        sw_irq;

    logic [31:0] csr_out,     nv_csr_out;
    logic        csr_illegal, nv_csr_illegal;
    logic        irq_pending, nv_irq_pending;
    logic [31:0] irq_cause,   nv_irq_cause;
    logic [31:0] trap_target, nv_trap_target;
    logic [31:0] mepc_out,    nv_mepc_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_file_mtrap #(
        .HART_ID(32'd0), .RESET_PC(32'h0001_0000),
        .MTVEC_VECTORED_OK(1'b1), .IRQ_SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_out(csr_out),
        .csr_illegal(csr_illegal), .csr_wr_addr(csr_wr_addr), .csr_data_in(csr_data_in),
        .wr_csr_n(wr_csr_n), .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_val(trap_val), .is_mret(is_mret),
        .instr_retired(instr_retired), .ext_irq(ext_irq), .timer_irq(timer_irq),
        .sw_irq(sw_irq), .irq_pending(irq_pending), .irq_cause(irq_cause),
        .trap_target(trap_target), .mepc_out(mepc_out)
    );

    csr_file_mtrap #(
        .HART_ID(32'd0), .RESET_PC(32'h0001_0000),
        .MTVEC_VECTORED_OK(1'b0), .IRQ_SYNC_STAGES(SYNC)
    ) dut_nv (
        .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_out(nv_csr_out),
        .csr_illegal(nv_csr_illegal), .csr_wr_addr(csr_wr_addr), .csr_data_in(csr_data_in),
        .wr_csr_n(wr_csr_n), .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_val(trap_val), .is_mret(is_mret),
        .instr_retired(instr_retired), .ext_irq(ext_irq), .timer_irq(timer_irq),
        .sw_irq(sw_irq), .irq_pending(nv_irq_pending), .irq_cause(nv_irq_cause),
        .trap_target(nv_trap_target), .mepc_out(nv_mepc_out)
    );

    task automatic rd(input logic [11:0] a);
        csr_addr = a;
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_wr_addr = a;
        csr_data_in = d;
        wr_csr_n    = 1'b0;
        @(negedge clk);
        wr_csr_n    = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; csr_addr = 12'h341; csr_wr_addr = '0; csr_data_in = '0; wr_csr_n = 1'b1;
        trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_val = '0; is_mret = 1'b0;
        instr_retired = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(12'h341);
        n_checks++; if (csr_out !== 32'h0001_0000) begin n_fail++; $display("FAIL reset_mepc: got %h exp %h", csr_out, 32'h0001_0000); end
        rd(12'h300);
        n_checks++; if (csr_out !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus: got %h exp %h", csr_out, 32'h0000_1800); end
        rd(12'h305);
        n_checks++; if (csr_out !== 32'h0001_0000) begin n_fail++; $display("FAIL reset_mtvec: got %h exp %h", csr_out, 32'h0001_0000); end
        rd(12'h7C0);
        n_checks++; if (csr_out !== 32'h0 || csr_illegal !== 1'b1) begin n_fail++; $display("FAIL reset_illegal: got out=%h ill=%b exp 0/1", csr_out, csr_illegal); end
        n_checks++; if (irq_pending !== 1'b0 || irq_cause !== 32'h8000_000B) begin n_fail++; $display("FAIL reset_irq: got %b/%h exp 0/8000000b", irq_pending, irq_cause); end
        n_checks++; if (mepc_out !== 32'h0001_0000) begin n_fail++; $display("FAIL reset_mepc_out: got %h exp %h", mepc_out, 32'h0001_0000); end
    endtask

    task automatic test_vectored_trap;
        csr_write(12'h305, 32'h0000_2001);
        csr_write(12'h300, 32'h0000_0008);
        trap_req = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h104; trap_val = 32'h55;
        rd(12'h341);
        n_checks++; if (trap_target !== 32'h0000_201C) begin n_fail++; $display("FAIL vec_target: got %h exp %h", trap_target, 32'h0000_201C); end
        n_checks++; if (csr_out !== 32'h0001_0000) begin n_fail++; $display("FAIL no_bypass_mepc: got %h exp %h", csr_out, 32'h0001_0000); end
        @(negedge clk);
        trap_req = 1'b0;
        rd(12'h341);
        n_checks++; if (csr_out !== 32'h0000_0104) begin n_fail++; $display("FAIL trap_mepc: got %h exp %h", csr_out, 32'h104); end
        rd(12'h300);
        n_checks++; if (csr_out !== 32'h0000_1880) begin n_fail++; $display("FAIL trap_mstatus: got %h exp %h", csr_out, 32'h1880); end
        rd(12'h342);
        n_checks++; if (csr_out !== 32'h8000_0007) begin n_fail++; $display("FAIL trap_mcause: got %h exp %h", csr_out, 32'h8000_0007); end
        rd(12'h343);
        n_checks++; if (csr_out !== 32'h0000_0055) begin n_fail++; $display("FAIL trap_mtval: got %h exp %h", csr_out, 32'h55); end
        n_checks++; if (mepc_out !== 32'h0000_0104) begin n_fail++; $display("FAIL trap_mepc_out: got %h exp %h", mepc_out, 32'h104); end
    endtask

    task automatic test_mret_collision;
        csr_write(12'h340, 32'h0000_CAFE);
        rd(12'h340);
        n_checks++; if (csr_out !== 32'h0000_CAFE) begin n_fail++; $display("FAIL mscratch_wr: got %h exp %h", csr_out, 32'hCAFE); end
        is_mret = 1'b1;
        csr_write(12'h340, 32'h0000_1234);
        is_mret = 1'b0;
        rd(12'h300);
        n_checks++; if (csr_out !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus: got %h exp %h", csr_out, 32'h1888); end
        rd(12'h340);
        n_checks++; if (csr_out !== 32'h0000_CAFE) begin n_fail++; $display("FAIL mret_drops_wr: got %h exp %h", csr_out, 32'hCAFE); end
        trap_req = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_020B; trap_val = 32'h0BAD;
        #1;
        n_checks++; if (trap_target !== 32'h0000_2000) begin n_fail++; $display("FAIL exc_target: got %h exp %h", trap_target, 32'h2000); end
        csr_write(12'h340, 32'h0000_DEAD);
        trap_req = 1'b0;
        rd(12'h340);
        n_checks++; if (csr_out !== 32'h0000_CAFE) begin n_fail++; $display("FAIL trap_drops_wr: got %h exp %h", csr_out, 32'hCAFE); end
        rd(12'h341);
        n_checks++; if (csr_out !== 32'h0000_0208) begin n_fail++; $display("FAIL trap2_mepc: got %h exp %h", csr_out, 32'h208); end
        rd(12'h342);
        n_checks++; if (csr_out !== 32'h0000_0002) begin n_fail++; $display("FAIL trap2_mcause: got %h exp %h", csr_out, 32'h2); end
        rd(12'h300);
        n_checks++; if (csr_out !== 32'h0000_1880) begin n_fail++; $display("FAIL trap2_mstatus: got %h exp %h", csr_out, 32'h1880); end
    endtask

    task automatic test_interrupt;
        csr_write(12'h304, 32'hFFFF_FFFF);
        rd(12'h304);
        n_checks++; if (csr_out !== 32'h0000_0888) begin n_fail++; $display("FAIL mie_mask: got %h exp %h", csr_out, 32'h888); end
        csr_write(12'h304, 32'h0000_0800);
        csr_write(12'h300, 32'h0000_0008);
        rd(12'h300);
        n_checks++; if (csr_out !== 32'h0000_1808) begin n_fail++; $display("FAIL mstatus_wr: got %h exp %h", csr_out, 32'h1808); end
        n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b exp 0", irq_pending); end
        ext_irq = 1'b1;
        for (int i = 1; i <= SYNC; i++) begin
            @(negedge clk);
            n_checks++; if (irq_pending !== (i == SYNC)) begin n_fail++; $display("FAIL irq_latency_%0d: got %b exp %b", i, irq_pending, (i == SYNC)); end
        end
        n_checks++; if (irq_cause !== 32'h8000_000B) begin n_fail++; $display("FAIL irq_cause_mei: got %h exp %h", irq_cause, 32'h8000_000B); end
        rd(12'h344);
        n_checks++; if (csr_out !== 32'h0000_0800) begin n_fail++; $display("FAIL mip_read: got %h exp %h", csr_out, 32'h800); end
        csr_write(12'h344, 32'h0);
        rd(12'h344);
        n_checks++; if (csr_out !== 32'h0000_0800) begin n_fail++; $display("FAIL mip_ro: got %h exp %h", csr_out, 32'h800); end
        timer_irq = 1'b1;
        csr_write(12'h304, 32'h0000_0080);
        @(negedge clk);
        #1;
        n_checks++; if (irq_pending !== 1'b1 || irq_cause !== 32'h8000_0007) begin n_fail++; $display("FAIL irq_mti: got %b/%h exp 1/80000007", irq_pending, irq_cause); end
        sw_irq = 1'b1;
        csr_write(12'h304, 32'h0000_0888);
        #1;
        n_checks++; if (irq_cause !== 32'h8000_000B) begin n_fail++; $display("FAIL irq_prio_mei: got %h exp %h", irq_cause, 32'h8000_000B); end
        @(negedge clk);
        csr_write(12'h304, 32'h0000_0088);
        #1;
        n_checks++; if (irq_cause !== 32'h8000_0003) begin n_fail++; $display("FAIL irq_prio_msi: got %h exp %h", irq_cause, 32'h8000_0003); end
        csr_write(12'h300, 32'h0);
        #1;
        n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_mie_gate: got %b exp 0", irq_pending); end
        ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        rd(12'h344);
        n_checks++; if (csr_out !== 32'h0) begin n_fail++; $display("FAIL mip_clear: got %h exp 0", csr_out); end
    endtask

    task automatic test_mtvec_warl;
        csr_write(12'h305, 32'h0000_3003);
        rd(12'h305);
        n_checks++; if (csr_out !== 32'h0000_3001) begin n_fail++; $display("FAIL warl_mode11: got %h exp %h", csr_out, 32'h3001); end
        csr_write(12'h305, 32'h0000_5001);
        rd(12'h305);
        n_checks++; if (nv_csr_out !== 32'h0000_5000) begin n_fail++; $display("FAIL warl_novec: got %h exp %h", nv_csr_out, 32'h5000); end
        n_checks++; if (csr_out !== 32'h0000_5001) begin n_fail++; $display("FAIL warl_vec: got %h exp %h", csr_out, 32'h5001); end
        csr_write(12'h305, 32'h0000_6002);
        rd(12'h305);
        n_checks++; if (csr_out !== 32'h0000_6001) begin n_fail++; $display("FAIL warl_mode10: got %h exp %h", csr_out, 32'h6001); end
        csr_write(12'h305, 32'h0000_7000);
        rd(12'h305);
        n_checks++; if (csr_out !== 32'h0000_7000) begin n_fail++; $display("FAIL warl_mode00: got %h exp %h", csr_out, 32'h7000); end
        csr_write(12'h341, 32'h0000_0333);
        rd(12'h341);
        n_checks++; if (csr_out !== 32'h0000_0330) begin n_fail++; $display("FAIL mepc_align: got %h exp %h", csr_out, 32'h330); end
    endtask

    task automatic test_readonly;
        csr_write(12'h301, 32'h0);
        rd(12'h301);
        n_checks++; if (csr_out !== 32'h4000_0100 || csr_illegal !== 1'b0) begin n_fail++; $display("FAIL misa_ro: got %h/%b exp 40000100/0", csr_out, csr_illegal); end
        csr_write(12'hF14, 32'hFFFF_FFFF);
        rd(12'hF14);
        n_checks++; if (csr_out !== 32'h0 || csr_illegal !== 1'b0) begin n_fail++; $display("FAIL mhartid: got %h/%b exp 0/0", csr_out, csr_illegal); end
    endtask

    task automatic test_counters;
`ifdef CSR_COUNTERS_EN
        logic [31:0] base;
        csr_write(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00);
        n_checks++; if (csr_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_wr_lo: got %h exp ffffffff", csr_out); end
        rd(12'hB80);
        n_checks++; if (csr_out !== 32'h0) begin n_fail++; $display("FAIL mcycle_wr_hi: got %h exp 0", csr_out); end
        @(negedge clk);
        rd(12'hB00);
        n_checks++; if (csr_out !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_lo: got %h exp 0", csr_out); end
        rd(12'hB80);
        n_checks++; if (csr_out !== 32'h1) begin n_fail++; $display("FAIL mcycle_carry_hi: got %h exp 1", csr_out); end
        rd(12'hB02);
        base = csr_out;
        instr_retired = 1'b1;
        repeat (5) @(negedge clk);
        instr_retired = 1'b0;
        #1;
        n_checks++; if (csr_out !== base + 32'd5) begin n_fail++; $display("FAIL minstret_5: got %h exp %h", csr_out, base + 32'd5); end
        @(negedge clk);
        #1;
        n_checks++; if (csr_out !== base + 32'd5) begin n_fail++; $display("FAIL minstret_hold: got %h exp %h", csr_out, base + 32'd5); end
`else
        rd(12'hB00);
        n_checks++; if (csr_out !== 32'h0 || csr_illegal !== 1'b1) begin n_fail++; $display("FAIL mcycle_absent: got %h/%b exp 0/1", csr_out, csr_illegal); end
        rd(12'hB82);
        n_checks++; if (csr_out !== 32'h0 || csr_illegal !== 1'b1) begin n_fail++; $display("FAIL minstreth_absent: got %h/%b exp 0/1", csr_out, csr_illegal); end
`endif
    endtask

    task automatic test_async_reset;
        csr_addr = 12'h340;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (csr_out !== 32'h0) begin n_fail++; $display("FAIL areset_mscratch: got %h exp 0", csr_out); end
        rd(12'h305);
        n_checks++; if (csr_out !== 32'h0001_0000) begin n_fail++; $display("FAIL areset_mtvec: got %h exp %h", csr_out, 32'h0001_0000); end
        @(negedge clk);
        rst_n = 1'b1;
        rd(12'h300);
        n_checks++; if (csr_out !== 32'h0000_1800) begin n_fail++; $display("FAIL areset_mstatus: got %h exp %h", csr_out, 32'h1800); end
    endtask

    initial begin
        test_reset();
        test_vectored_trap();
        test_mret_collision();
        test_interrupt();
        test_mtvec_warl();
        test_readonly();
        test_counters();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csr_file_mtrap.md
Name: csr_file_mtrap

Overview:
Machine-mode-only CSR file for the RV32I pipeline that owns architectural trap state, not just storage. It accepts trap-entry and MRET events from the commit stage and updates mstatus, mepc, mcause and mtval atomically. It samples interrupt lines into mip, raises a qualified interrupt request, and computes the trap target PC, including vectored mode. It replaces the fixed, read-only-mtvec CSR block in the ID/WB path.

Parameters:
HART_ID, 0, value returned by mhartid.
RESET_PC, 32'h0001_0000, reset value of mepc and of mtvec BASE (matches pc_reg).
MTVEC_VECTORED_OK, 1, 1 allows mtvec MODE=01 (vectored); 0 forces MODE=00.
IRQ_SYNC_STAGES, 2, flop stages on each asynchronous interrupt input (1..3).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_addr  in  12  read address
csr_out  out  32  read data, combinational from current state; 0 for unimplemented addresses
csr_illegal  out  1  csr_addr is not implemented (combinational)
csr_wr_addr  in  12  write address
csr_data_in  in  32  write data, already merged for CSRRS/CSRRC by the caller
wr_csr_n  in  1  active-low write enable
trap_req  in  1  take exception or interrupt this cycle
trap_cause  in  32  mcause value; bit31 set means interrupt
trap_pc  in  32  faulting or interrupted PC
trap_val  in  32  mtval value
is_mret  in  1  MRET commits this cycle
instr_retired  in  1  one instruction retired this cycle
ext_irq, timer_irq, sw_irq  in  1 each  raw interrupt lines
irq_pending  out  1  enabled interrupt pending and mstatus.MIE=1
irq_cause  out  32  cause of the highest-priority pending interrupt (MEI 11 > MSI 3 > MTI 7), bit31 set
trap_target  out  32  next PC for the trap_req presented this cycle
mepc_out  out  32  current mepc, used as the MRET target

Behaviour:
- Reset values:
  - mstatus: MIE=0, MPIE=0, MPP=2'b11.
  - mie=0, mip=0, mscratch=0, mcause=0, mtval=0.
  - mepc=RESET_PC; mtvec={RESET_PC[31:2],2'b00}.
  - Counters=0; synchronisers=0.
  - Outputs follow from this state: irq_pending=0, irq_cause=32'h8000_000B.
- Writes take effect at the next clk edge. Same-cycle reads return the old value; there is no internal bypass.
- Per-cycle priority: trap_req > is_mret > CSR write. A lower-priority event in the same cycle is dropped entirely, including writes to unrelated CSRs.
- Trap entry:
  - mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_val.
  - MPIE<=MIE, MIE<=0, MPP<=11.
- MRET: MIE<=MPIE, MPIE<=1, MPP stays 11.
- mstatus writes: only MIE (bit 3) and MPIE (bit 7) are writable. MPP reads 11; all other bits read 0.
- mie writes: only bits 3, 7, 11 are writable; other bits read 0.
- mip:
  - MEIP, MTIP and MSIP are read-only and equal the last synchroniser stage of ext, timer and sw lines respectively.
  - Writes to mip are ignored. Interrupt latency is IRQ_SYNC_STAGES cycles.
- irq_pending = MIE & |(mie & mip).
- mtvec:
  - BASE bits [31:2] are writable.
  - MODE write of 00 is stored. Write of 01 is stored if MTVEC_VECTORED_OK=1, otherwise it becomes 00.
  - MODE writes of 10 or 11 keep the previous MODE (WARL).
- trap_target:
  - BASE when MODE=00 or trap_cause[31]=0.
  - Otherwise BASE + 4*trap_cause[4:0], with 32-bit wrap.
- mepc writes clear bits [1:0]. mscratch, mcause and mtval are fully writable.
- Read-only CSRs: mvendorid=0, marchid=0, mimpid=0, mhartid=HART_ID, misa=32'h4000_0100. Writes to them are ignored.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous reset).

Optional Feature:
CSR_COUNTERS_EN.
- Defined: adds 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82).
  - mcycle increments every cycle; minstret increments when instr_retired=1.
  - Both wrap to 0 from all-ones.
  - A CSR write to a half replaces that half. The other half is not incremented that cycle, and carry from the written half is suppressed.
  - Trap entry does not stop counting.
- Undefined: those addresses read 0 and set csr_illegal=1, and no counter flops are instantiated.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams.
  - mstatus, mie and mip bit indices.
  - mtvec MODE encodings.
  - Interrupt cause codes (3, 7, 11).
  - The misa constant.
- One natural sub-module: csr_irq_sync (parametrised IRQ_SYNC_STAGES flop chain per line), instantiated three times.
- The counters stay inline under the macro.

Test Plan:
- Reset: read 0x341 -> 32'h0001_0000; read 0x300 -> 32'h0000_1800; read 0x7C0 -> csr_out=0, csr_illegal=1.
- Vectored trap: write mtvec=32'h0000_2001, mstatus=32'h8, then trap_req with cause 32'h8000_0007 and pc 32'h104 -> trap_target=32'h0000_201C same cycle; next cycle mepc=32'h104 and mstatus=32'h1880.
- MRET then collision: MRET after the trap above -> mstatus=32'h1888. Then assert trap_req and a write of 0x340=32'hDEAD in the same cycle -> mscratch unchanged and trap state updated.
- Interrupt: mie=32'h800 and MIE=1, raise ext_irq -> irq_pending rises exactly IRQ_SYNC_STAGES cycles later and irq_cause=32'h8000_000B. Then write mip=0 -> mip unchanged.
- mtvec WARL: write 32'h0000_3003 over MODE=01 -> reads 32'h0000_3001. With MTVEC_VECTORED_OK=0, write 32'h5001 -> reads 32'h5000.
- Counters (CSR_COUNTERS_EN): write mcycle low=32'hFFFF_FFFF -> next cycle low=32'hFFFF_FFFF and high=0. The cycle after that gives low=0 and high=1. With instr_retired held for 5 cycles, minstret advances by 5.
